ac_level_vlc_encoder: RTL and testbench

Parametrised, streaming entropy coder for ProRes AC level coefficients. It accepts one signed quantised coefficient per handshake and emits one right-aligned codeword and its bit length per coefficient. Codebook selection adapts to the previous nonzero level. The block sits between the run/level splitter and the slice bit packer. Compared with the fixed-width, non-stallable level coder it replaces, it adds:

- parametrised widths;
- valid/ready backpressure;
- an explicit start-of-block restart;
- an optional bit counter.

---
 rtl/ac_level_vlc_encoder_pkg.sv | 42 ++++
 rtl/ac_level_vlc_encoder_codeword_builder.sv | 37 +++
 rtl/ac_level_vlc_encoder.sv | 159 +++++++++++++++
 tb/tb_ac_level_vlc_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_level_vlc_encoder_pkg.sv
// Codebook types and per-prev constants for the adaptive AC level coder.
package ac_vlc_pkg;

    typedef enum logic {RICE_EXPG, EXPG} codebook_e;

    // Rice escape thresholds for prev 0..2 (hybrid codebooks)
    localparam logic [1:0] RICE_T_P0 = 2'd3;
    localparam logic [1:0] RICE_T_P1 = 2'd2;
    localparam logic [1:0] RICE_T_P2 = 2'd3;

    // Exp-Golomb orders by prev class
    localparam logic [1:0] EXPG_K_P0    = 2'd2;
    localparam logic [1:0] EXPG_K_P1    = 2'd1;
    localparam logic [1:0] EXPG_K_P2    = 2'd1;
    localparam logic [1:0] EXPG_K_P3    = 2'd0;
    localparam logic [1:0] EXPG_K_P4_7  = 2'd1;
    localparam logic [1:0] EXPG_K_P8_UP = 2'd2;

    // p is prev clamped to 8, so 8 stands for every prev >= 8
    function automatic codebook_e codebook_of(input logic [3:0] p);
        return (p < 4'd3) ? RICE_EXPG : EXPG;
    endfunction

    function automatic logic [1:0] thresh_of(input logic [3:0] p);
        case (p)
            4'd0:    return RICE_T_P0;
            4'd1:    return RICE_T_P1;
            4'd2:    return RICE_T_P2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] order_of(input logic [3:0] p);
        if (p == 4'd0)      return EXPG_K_P0;
        else if (p == 4'd1) return EXPG_K_P1;
        else if (p == 4'd2) return EXPG_K_P2;
        else if (p == 4'd3) return EXPG_K_P3;
        else if (p < 4'd8)  return EXPG_K_P4_7;
        else                return EXPG_K_P8_UP;
    endfunction

endpackage

// File: rtl/ac_level_vlc_encoder_codeword_builder.sv
// Leading-one detect plus unary / exp-Golomb codeword and length assembly,
// with a trailing sign bit. Shared by the DC, run and AC level coders.
module vlc_codeword_builder #(
    parameter int unsigned CW_W  = 48,
    parameter int unsigned LEN_W = 6
) (
    input  logic             en_i,
    input  logic             eg_i,
    input  logic [CW_W-1:0]  q_i,
    input  logic [LEN_W-1:0] k_i,
    input  logic [LEN_W-1:0] prefix_i,
    input  logic             sign_i,
    output logic [CW_W-1:0]  code_o,
    output logic [LEN_W-1:0] len_o
);

    int unsigned     n;
    int unsigned     body;
    logic [CW_W-1:0] val;

    // eg_i=0: prefix_i zeros then a 1; eg_i=1: prefix_i zeros then exp-Golomb(q_i, k_i)
    always_comb begin
        n = 0;
        for (int unsigned i = 0; i < CW_W; i++) begin
            if (q_i[i]) n = i;
        end
        val    = eg_i ? q_i : CW_W'(1);
        body   = eg_i ? (32'(prefix_i) + 2 * n + 1 - 32'(k_i)) : (32'(prefix_i) + 1);
        code_o = '0;
        len_o  = '0;
        if (en_i) begin
            code_o = (val << 1) | CW_W'(sign_i);
            len_o  = LEN_W'(body + 1);
        end
    end

endmodule

// File: rtl/ac_level_vlc_encoder.sv
// Three-stage adaptive AC level VLC encoder with valid/ready backpressure.
// Optional running bit counter: define AC_VLC_BITCOUNT_EN.
module ac_level_vlc_encoder
    import ac_vlc_pkg::*;
#(
    parameter int unsigned COEFF_W = 20,
    parameter int unsigned CW_W    = 48,
    parameter int unsigned LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW_W-1:0]    out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic [31:0]        bit_count
);

    logic advance;

    logic               s1_valid_q, s1_sop_q, s1_sign_q, s1_zero_q;
    logic [COEFF_W:0]   s1_abs_q;
    logic               s2_valid_q, s2_zero_q, s2_sign_q, s2_eg_q;
    logic [COEFF_W-1:0] s2_q_q;
    logic [1:0]         s2_k_q, s2_pre_q;
    logic               out_valid_q;
    logic [CW_W-1:0]    out_code_q;
    logic [LEN_W-1:0]   out_len_q;
    logic [COEFF_W-1:0] prev_q;

    logic               s1_sign_d, s1_zero_d;
    logic [COEFF_W:0]   s1_abs_d;
    logic [COEFF_W-1:0] eff_prev, v_d, u_d, q_d;
    logic [3:0]         p_sel;
    codebook_e          cb;
    logic [1:0]         t_sel, k_sel, pre_d;
    logic               eg_d;
    logic [CW_W-1:0]    bld_code;
    logic [LEN_W-1:0]   bld_len;

    assign advance   = out_ready | ~out_valid_q;
    assign in_ready  = advance & ~reset;
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_len   = out_len_q;

    // |coeff| in COEFF_W+1 bits so the most negative value stays exact
    always_comb begin
        s1_sign_d = in_coeff[COEFF_W-1];
        s1_zero_d = (in_coeff == '0);
        s1_abs_d  = s1_sign_d ? ((COEFF_W+1)'(0) - {1'b1, in_coeff}) : {1'b0, in_coeff};
    end

    always_comb begin
        eff_prev = s1_sop_q ? COEFF_W'(1) : prev_q;
        p_sel    = (eff_prev > COEFF_W'(8)) ? 4'd8 : eff_prev[3:0];
        cb       = codebook_of(p_sel);
        t_sel    = thresh_of(p_sel);
        k_sel    = order_of(p_sel);
        v_d      = COEFF_W'(s1_abs_q - (COEFF_W+1)'(1));
        eg_d     = 1'b1;
        pre_d    = '0;
        u_d      = v_d;
        if (cb == RICE_EXPG) begin
            if (v_d < COEFF_W'(t_sel)) begin
                eg_d  = 1'b0;
                pre_d = v_d[1:0];
            end else begin
                pre_d = t_sel;
                u_d   = v_d - COEFF_W'(t_sel);
            end
        end
        q_d = u_d + (COEFF_W'(1) << k_sel);
    end

    vlc_codeword_builder #(
        .CW_W  (CW_W),
        .LEN_W (LEN_W)
    ) u_builder (
        .en_i     (~s2_zero_q),
        .eg_i     (s2_eg_q),
        .q_i      (CW_W'(s2_q_q)),
        .k_i      (LEN_W'(s2_k_q)),
        .prefix_i (LEN_W'(s2_pre_q)),
        .sign_i   (s2_sign_q),
        .code_o   (bld_code),
        .len_o    (bld_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b1;
            s1_abs_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_zero_q   <= 1'b1;
            s2_sign_q   <= 1'b0;
            s2_eg_q     <= 1'b0;
            s2_q_q      <= '0;
            s2_k_q      <= '0;
            s2_pre_q    <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_len_q   <= '0;
            prev_q      <= COEFF_W'(1);
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_sop_q    <= in_sop;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_abs_q    <= s1_abs_d;
            s2_valid_q  <= s1_valid_q;
            s2_zero_q   <= s1_zero_q;
            s2_sign_q   <= s1_sign_q;
            s2_eg_q     <= eg_d;
            s2_q_q      <= q_d;
            s2_k_q      <= k_sel;
            s2_pre_q    <= pre_d;
            if (s1_valid_q && !s1_zero_q) prev_q <= v_d;
            out_valid_q <= s2_valid_q;
            out_code_q  <= s2_valid_q ? bld_code : '0;
            out_len_q   <= s2_valid_q ? bld_len : '0;
        end
    end

`ifdef AC_VLC_BITCOUNT_EN
    logic        s2_sop_q, out_sop_q;
    logic [31:0] bc_q;
    logic [32:0] bc_sum;

    always_comb bc_sum = {1'b0, bc_q} + 33'(out_len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_sop_q  <= 1'b0;
            out_sop_q <= 1'b0;
            bc_q      <= '0;
        end else begin
            if (advance) begin
                s2_sop_q  <= s1_sop_q;
                out_sop_q <= s2_sop_q;
            end
            if (out_valid_q && out_ready)
                bc_q <= out_sop_q ? 32'(out_len_q) : (bc_sum[32] ? '1 : bc_sum[31:0]);
        end
    end

    assign bit_count = bc_q;
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_ac_level_vlc_encoder.sv
// Directed and scoreboarded bench for ac_level_vlc_encoder.
module tb_ac_level_vlc_encoder;

    localparam int unsigned COEFF_W = 20;
    localparam int unsigned CW_W    = 48;
    localparam int unsigned LEN_W   = 6;

    logic                      clk = 1'b0;
    logic                      reset, in_valid, in_ready, in_sop, out_valid, out_ready;
    logic signed [COEFF_W-1:0] in_coeff;
    logic [CW_W-1:0]           out_code;
    logic [LEN_W-1:0]          out_len;
    logic [31:0]               bit_count;

    always #5 clk = ~clk;

    ac_level_vlc_encoder #(
        .COEFF_W (COEFF_W),
        .CW_W    (CW_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_len   (out_len),
        .bit_count (bit_count)
    );

    int errors = 0;
    int checks = 0;

    logic [COEFF_W-1:0]        m_prev;
    longint unsigned           m_bc;
    logic [CW_W-1:0]           exp_code[$];
    int unsigned               exp_len[$];
    bit                        exp_sop[$];
    logic [63:0]               got_code[$], got_len[$], got_bc[$];
    logic signed [COEFF_W-1:0] vec[$];
    bit                        vsop[$];
    bit                        acc, held, bc_pend;
    logic [CW_W-1:0]           held_code;
    logic [LEN_W-1:0]          held_len;
    int                        cyc, first_acc, first_ov, n_acc;

    logic [63:0] e1c[5] = '{64'd2, 64'd3, 64'd6, 64'd0, 64'd6};
    logic [63:0] e1l[5] = '{64'd2, 64'd4, 64'd6, 64'd0, 64'd3};
    logic [63:0] e1b[5] = '{64'd2, 64'd6, 64'd12, 64'd12, 64'd15};
    logic [63:0] e2c[5] = '{64'd38, 64'd207, 64'h100007, 64'd26, 64'd2};
    logic [63:0] e2l[5] = '{64'd11, 64'd12, 64'd38, 64'd6, 64'd2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bit-serial reference encoder, independent of the pipelined datapath
    task automatic model(input logic signed [COEFF_W-1:0] c, input bit sop,
                         output logic [CW_W-1:0] code, output int unsigned len);
        longint v, u, q;
        int     p, t, k, n;
        bit     hyb;
        code = '0;
        len  = 0;
        if (c == 0) return;
        v   = ((c < 0) ? -longint'(c) : longint'(c)) - 1;
        p   = sop ? 1 : int'(m_prev);
        hyb = (p <= 2);
        t   = (p == 1) ? 2 : 3;
        if (p == 0) k = 2;
        else if (p <= 2) k = 1;
        else if (p == 3) k = 0;
        else if (p < 8) k = 1;
        else k = 2;
        if (hyb && v < t) begin
            for (longint i = 0; i < v; i++) begin code = code << 1; len++; end
            code = (code << 1) | 1; len++;
        end else begin
            u = v;
            if (hyb) begin
                for (int i = 0; i < t; i++) begin code = code << 1; len++; end
                u = v - t;
            end
            q = u + (longint'(1) << k);
            n = 0;
            while ((q >> (n + 1)) != 0) n++;
            for (int i = 0; i < n - k; i++) begin code = code << 1; len++; end
            for (int i = n; i >= 0; i--) begin code = (code << 1) | CW_W'(q[i]); len++; end
        end
        code = (code << 1) | CW_W'(c < 0);
        len++;
        m_prev = COEFF_W'(v);
    endtask

    task automatic tick();
        logic [CW_W-1:0] mc;
        int unsigned     ml;
        longint unsigned eb;
        #1;
        if (bc_pend) begin
            got_bc.push_back(64'(bit_count));
`ifdef AC_VLC_BITCOUNT_EN
            eb = m_bc;
`else
            eb = 0;
`endif
            check("bit_count", 64'(bit_count), eb);
            bc_pend = 0;
        end
        if (held) begin
            check("hold_code", 64'(out_code), 64'(held_code));
            check("hold_len", 64'(out_len), 64'(held_len));
        end
        held      = out_valid && !out_ready;
        held_code = out_code;
        held_len  = out_len;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            if (exp_code.size() == 0) begin
                check("extra_output", 64'(out_valid), 64'd0);
            end else begin
                check("out_code", 64'(out_code), 64'(exp_code[0]));
                check("out_len", 64'(out_len), 64'(exp_len[0]));
                if (exp_sop[0]) m_bc = out_len;
                else m_bc = (m_bc + out_len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bc + out_len;
                void'(exp_code.pop_front());
                void'(exp_len.pop_front());
                void'(exp_sop.pop_front());
            end
            got_code.push_back(64'(out_code));
            got_len.push_back(64'(out_len));
            bc_pend = 1;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            model(in_coeff, in_sop, mc, ml);
            exp_code.push_back(mc);
            exp_len.push_back(ml);
            exp_sop.push_back(in_sop);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_stream(input bit rnd_ready);
        int idx    = 0;
        int budget = 20000;
        while ((idx < vec.size() || exp_code.size() > 0) && budget > 0) begin
            in_valid  = (idx < vec.size());
            in_coeff  = (idx < vec.size()) ? vec[idx] : '0;
            in_sop    = (idx < vec.size()) ? vsop[idx] : 1'b0;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (acc) idx++;
            budget--;
        end
        if (budget == 0) check("timeout_pending", 64'(exp_code.size()), 64'd0);
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        repeat (2) begin
            #1 check("in_ready_in_reset", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        exp_code.delete();
        exp_len.delete();
        exp_sop.delete();
        m_prev  = COEFF_W'(1);
        m_bc    = 0;
        held    = 0;
        bc_pend = 0;
    endtask

    task automatic clear_got();
        got_code.delete();
        got_len.delete();
        got_bc.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_coeff  = '0;
        out_ready = 1'b1;
        acc = 0; held = 0; bc_pend = 0;
        cyc = 0; first_acc = -1; first_ov = -1; n_acc = 0;
        @(negedge clk);
        apply_reset();

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_code", 64'(out_code), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Basic sequence with full-rate ready
        clear_got();
        vec  = '{20'sd1, -20'sd3, 20'sd5, 20'sd0, 20'sd2};
        vsop = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        cyc = 0; first_acc = -1; first_ov = -1;
        run_stream(1'b0);
        check("latency", 64'(first_ov - first_acc), 64'd3);
        check("seq1_count", 64'(got_code.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq1_code%0d", i), got_code[i], e1c[i]);
            check($sformatf("seq1_len%0d", i), got_len[i], e1l[i]);
`ifdef AC_VLC_BITCOUNT_EN
            check($sformatf("seq1_bc%0d", i), got_bc[i], e1b[i]);
`else
            check($sformatf("seq1_bc%0d", i), got_bc[i], 64'd0);
`endif
        end

        // Large prev, most negative value, sop restart after prev=9
        clear_got();
        vec  = '{20'sd20, -20'sd100, 20'sh80000, 20'sd10, 20'sd1};
        vsop = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(1'b0);
        check("seq2_count", 64'(got_code.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq2_code%0d", i), got_code[i], e2c[i]);
            check($sformatf("seq2_len%0d", i), got_len[i], e2l[i]);
        end
`ifdef AC_VLC_BITCOUNT_EN
        check("seq2_bc_sop_reload", got_bc[4], 64'd2);
`else
        check("seq2_bc_sop_reload", got_bc[4], 64'd0);
`endif

        // Random coefficients under random backpressure
        vec.delete();
        vsop.delete();
        for (int i = 0; i < 1000; i++) begin
            int unsigned r = $urandom_range(0, 3);
            logic signed [COEFF_W-1:0] c;
            case (r)
                0:       c = COEFF_W'($urandom_range(0, 8)) - 20'sd4;
                1:       c = COEFF_W'($urandom_range(0, 40)) - 20'sd20;
                2:       c = COEFF_W'($urandom);
                default: c = '0;
            endcase
            vec.push_back(c);
            vsop.push_back($urandom_range(0, 15) == 0);
        end
        run_stream(1'b1);

        // Reset with three beats in flight
        in_valid  = 1'b1;
        in_coeff  = 20'sd20;
        in_sop    = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        repeat (6) tick();
        check("inflight_accepted", 64'(n_acc), 64'd3);
        apply_reset();
        out_ready = 1'b1;
        repeat (4) begin
            #1 check("post_reset_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        clear_got();
        vec  = '{20'sd1};
        vsop = '{1'b0};
        run_stream(1'b0);
        check("post_reset_code", got_code[0], 64'd2);
        check("post_reset_len", got_len[0], 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
